// File: rtl/adder_share_arbiter_if.sv
// Requester/response bundle between two adder clients and the arbiter.
// The optional subtract strobes exist only when ADDER_SUB_EN is defined.
interface adder_share_arbiter_if #(
    parameter int WIDTH = 11
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_cin;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_cin;
`ifdef ADDER_SUB_EN
    logic             req0_sub;
    logic             req1_sub;
`endif
    logic             rsp0_valid;
    logic             rsp0_ready;
    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [WIDTH-1:0] rsp_sum;
    logic             rsp_cout;

    modport master (
        output req0_valid, req0_a, req0_b, req0_cin,
        output req1_valid, req1_a, req1_b, req1_cin,
`ifdef ADDER_SUB_EN
        output req0_sub, req1_sub,
`endif
        output rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid,
        input  rsp_sum, rsp_cout
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin,
        input  req1_valid, req1_a, req1_b, req1_cin,
`ifdef ADDER_SUB_EN
        input  req0_sub, req1_sub,
`endif
        input  rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid,
        output rsp_sum, rsp_cout
    );
endinterface

// File: rtl/adder_share_arbiter.sv
// Round-robin sharing of one external adder between two requesters.
// Optional ADDER_SUB_EN adds per-request subtract (A - B) support.
module adder_share_arbiter #(
    parameter int WIDTH   = 11,
    parameter bit RR_INIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    adder_share_arbiter_if.slave bus,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             prio_q, prio_d;
    logic             owner_q, owner_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             cin_q, cin_d;
    logic             sub_q, sub_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic gnt1;
    logic any_valid;
    logic rdy0, rdy1;
    logic own_ready;
    logic sub0, sub1;

`ifdef ADDER_SUB_EN
    assign sub0 = bus.req0_sub;
    assign sub1 = bus.req1_sub;
`else
    assign sub0 = 1'b0;
    assign sub1 = 1'b0;
`endif

    // Priority only breaks ties; a lone valid requester always wins.
    assign gnt1 = bus.req1_valid
                & (~bus.req0_valid | prio_q);
    assign any_valid = bus.req0_valid | bus.req1_valid;
    assign own_ready = owner_q ? bus.rsp1_ready
                               : bus.rsp0_ready;

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        owner_d = owner_q;
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        sub_d   = sub_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        rdy0    = 1'b0;
        rdy1    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rst_n && any_valid) begin
                    rdy0    = ~gnt1;
                    rdy1    = gnt1;
                    owner_d = gnt1;
                    a_d     = gnt1 ? bus.req1_a : bus.req0_a;
                    b_d     = gnt1 ? bus.req1_b : bus.req0_b;
                    cin_d   = gnt1 ? bus.req1_cin : bus.req0_cin;
                    sub_d   = gnt1 ? sub1 : sub0;
                    state_d = CALC;
                end
            end
            CALC: begin
                sum_d   = add_sum;
                cout_d  = add_cout;
                state_d = RESP;
            end
            RESP: begin
                if (own_ready) begin
                    prio_d  = ~owner_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            prio_q  <= RR_INIT;
            owner_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            sub_q   <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            owner_q <= owner_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            sub_q   <= sub_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    // Subtract is A + ~B + 1; the requester's carry-in is ignored.
    assign add_a   = a_q;
    assign add_b   = sub_q ? ~b_q : b_q;
    assign add_cin = sub_q | cin_q;

    assign bus.req0_ready = rdy0;
    assign bus.req1_ready = rdy1;
    assign bus.rsp0_valid = rst_n & (state_q == RESP) & ~owner_q;
    assign bus.rsp1_valid = rst_n & (state_q == RESP) & owner_q;
    assign bus.rsp_sum    = sum_q;
    assign bus.rsp_cout   = cout_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Randomised bench for adder_share_arbiter with a behavioural adder stub.
// Define ADDER_SUB_EN on both RTL and bench to exercise subtraction.
module tb_adder_share_arbiter;
    localparam int W = 11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    adder_share_arbiter_if #(.WIDTH(W)) bus ();

    logic [W-1:0] add_a, add_b, add_sum;
    logic         add_cin, add_cout;

    assign {add_cout, add_sum} = {1'b0, add_a}
                               + {1'b0, add_b}
                               + {{W{1'b0}}, add_cin};

    adder_share_arbiter #(.WIDTH(W), .RR_INIT(1'b0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout)
    );

    int n_chk = 0;
    int n_fail = 0;
    bit prio_m = 1'b0;

    // Reference: arithmetic result with carry as bit W.
    function automatic logic [W:0] ref_op(
        input logic [W-1:0] a,
        input logic [W-1:0] b,
        input logic         cin,
        input logic         sub
    );
        int unsigned s;
        int unsigned mask;
        mask = (1 << W) - 1;
        if (sub)
            s = int'(a) + ((~int'(b)) & mask) + 1;
        else
            s = int'(a) + int'(b) + int'(cin);
        return s[W:0];
    endfunction

    task automatic clear_inputs();
        bus.req0_valid = 0; bus.req0_a = '0;
        bus.req0_b = '0;    bus.req0_cin = 0;
        bus.req1_valid = 0; bus.req1_a = '0;
        bus.req1_b = '0;    bus.req1_cin = 0;
`ifdef ADDER_SUB_EN
        bus.req0_sub = 0;   bus.req1_sub = 0;
`endif
        bus.rsp0_ready = 0; bus.rsp1_ready = 0;
    endtask

    task automatic drive(
        input bit who, input logic [W-1:0] a,
        input logic [W-1:0] b, input logic cin
    );
        if (who) begin
            bus.req1_valid = 1; bus.req1_a = a;
            bus.req1_b = b;     bus.req1_cin = cin;
        end else begin
            bus.req0_valid = 1; bus.req0_a = a;
            bus.req0_b = b;     bus.req0_cin = cin;
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        drive(1'b0, 11'd1, 11'd2, 1'b0);
        repeat (3) begin
            @(posedge clk); @(negedge clk);
            n_chk++;
            if ({bus.req0_ready, bus.req1_ready,
                 bus.rsp0_valid, bus.rsp1_valid} !== 4'b0) begin
                n_fail++;
                $display("FAIL reset_hs got=%b%b%b%b want=0000",
                         bus.req0_ready, bus.req1_ready,
                         bus.rsp0_valid, bus.rsp1_valid);
            end
        end
        n_chk++;
        if (bus.rsp_sum !== '0 || bus.rsp_cout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_sum got=%h/%b want=0/0",
                     bus.rsp_sum, bus.rsp_cout);
        end
        rst_n = 1;
        #1;
        n_chk++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_first_grant got=%b%b want=10",
                     bus.req0_ready, bus.req1_ready);
        end
        @(posedge clk); @(negedge clk);
        bus.req0_valid = 0;
        @(posedge clk); @(negedge clk);
        n_chk++;
        if (bus.rsp0_valid !== 1'b1 || bus.rsp_sum !== 11'd3) begin
            n_fail++;
            $display("FAIL reset_op got=%b/%0d want=1/3",
                     bus.rsp0_valid, bus.rsp_sum);
        end
        bus.rsp0_ready = 1;
        @(posedge clk); @(negedge clk);
        bus.rsp0_ready = 0;
        prio_m = 1'b1;
    endtask

    task automatic test_single(
        input bit who, input logic [W-1:0] a,
        input logic [W-1:0] b, input logic cin
    );
        logic [W:0] exp;
        exp = ref_op(a, b, cin, 1'b0);
        drive(who, a, b, cin);
        #1;
        n_chk++;
        if (bus.req0_ready !== !who || bus.req1_ready !== who) begin
            n_fail++;
            $display("FAIL single_grant got=%b%b want_req1=%b",
                     bus.req0_ready, bus.req1_ready, who);
        end
        @(posedge clk); @(negedge clk);
        clear_inputs();
        n_chk++;
        if ({bus.req0_ready, bus.req1_ready,
             bus.rsp0_valid, bus.rsp1_valid} !== 4'b0) begin
            n_fail++;
            $display("FAIL single_calc got=%b%b%b%b want=0000",
                     bus.req0_ready, bus.req1_ready,
                     bus.rsp0_valid, bus.rsp1_valid);
        end
        @(posedge clk); @(negedge clk);
        n_chk++;
        if (bus.rsp0_valid !== !who || bus.rsp1_valid !== who
            || {bus.rsp_cout, bus.rsp_sum} !== exp) begin
            n_fail++;
            $display("FAIL single_rsp got=%b%b c=%b s=%h want_req1=%b c=%b s=%h",
                     bus.rsp0_valid, bus.rsp1_valid, bus.rsp_cout,
                     bus.rsp_sum, who, exp[W], exp[W-1:0]);
        end
        if (who) bus.rsp1_ready = 1;
        else     bus.rsp0_ready = 1;
        @(posedge clk); @(negedge clk);
        clear_inputs();
        prio_m = ~who;
    endtask

    task automatic test_contention();
        logic [W-1:0] qa [2];
        logic [W-1:0] qb [2];
        logic         qc [2];
        int           g [2];
        for (int r = 0; r < 2; r++) begin
            qa[r] = W'($urandom); qb[r] = W'($urandom);
            qc[r] = 1'($urandom); g[r] = 0;
        end
        for (int k = 0; k < 12; k++) begin
            bit got;
            bit who;
            int d;
            logic [W:0] exp;
            got = 0;
            drive(1'b0, qa[0], qb[0], qc[0]);
            drive(1'b1, qa[1], qb[1], qc[1]);
            for (int t = 0; t < 4 && !got; t++) begin
                #1;
                if (bus.req0_ready || bus.req1_ready) got = 1;
                else @(negedge clk);
            end
            n_chk++;
            if (!got) begin
                n_fail++;
                $display("FAIL cont_timeout op=%0d no grant", k);
                break;
            end
            who = bus.req1_ready;
            n_chk++;
            if (bus.req0_ready === bus.req1_ready || who !== prio_m) begin
                n_fail++;
                $display("FAIL cont_grant op=%0d got=%b%b want_req1=%b",
                         k, bus.req0_ready, bus.req1_ready, prio_m);
            end
            exp = ref_op(qa[who], qb[who], qc[who], 1'b0);
            @(posedge clk); @(negedge clk);
            qa[who] = W'($urandom); qb[who] = W'($urandom);
            qc[who] = 1'($urandom);
            drive(who, qa[who], qb[who], qc[who]);
            @(posedge clk); @(negedge clk);
            d = $urandom_range(0, 2);
            for (int c = 0; c <= d; c++) begin
                n_chk++;
                if (bus.rsp0_valid !== !who || bus.rsp1_valid !== who
                    || bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0
                    || {bus.rsp_cout, bus.rsp_sum} !== exp) begin
                    n_fail++;
                    $display("FAIL cont_rsp op=%0d v=%b%b c=%b s=%h want_req1=%b c=%b s=%h",
                             k, bus.rsp0_valid, bus.rsp1_valid,
                             bus.rsp_cout, bus.rsp_sum,
                             who, exp[W], exp[W-1:0]);
                end
                // The non-owner's ready is noise and must be ignored.
                if (who) bus.rsp0_ready = 1'($urandom);
                else     bus.rsp1_ready = 1'($urandom);
                if (c == d) begin
                    if (who) bus.rsp1_ready = 1;
                    else     bus.rsp0_ready = 1;
                end
                @(posedge clk); @(negedge clk);
            end
            bus.rsp0_ready = 0; bus.rsp1_ready = 0;
            g[who]++;
            prio_m = ~who;
        end
        n_chk++;
        if (g[0] != 6 || g[1] != 6) begin
            n_fail++;
            $display("FAIL cont_count got=%0d/%0d want=6/6", g[0], g[1]);
        end
        clear_inputs();
    endtask

    task automatic test_backpressure();
        logic [W-1:0] a, b;
        logic         cin;
        logic [W:0]   exp;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        exp = ref_op(a, b, cin, 1'b0);
        drive(1'b0, a, b, cin);
        @(posedge clk); @(negedge clk);
        bus.req0_valid = 0;
        drive(1'b1, W'($urandom), W'($urandom), 1'b0);
        @(posedge clk); @(negedge clk);
        bus.rsp1_ready = 1;
        repeat (5) begin
            n_chk++;
            if (bus.rsp0_valid !== 1'b1 || bus.rsp1_valid !== 1'b0
                || bus.req1_ready !== 1'b0
                || {bus.rsp_cout, bus.rsp_sum} !== exp) begin
                n_fail++;
                $display("FAIL bp_hold v=%b%b r1=%b c=%b s=%h want c=%b s=%h",
                         bus.rsp0_valid, bus.rsp1_valid, bus.req1_ready,
                         bus.rsp_cout, bus.rsp_sum, exp[W], exp[W-1:0]);
            end
            @(posedge clk); @(negedge clk);
        end
        bus.rsp0_ready = 1; bus.rsp1_ready = 0;
        @(posedge clk); @(negedge clk);
        bus.rsp0_ready = 0;
        #1;
        n_chk++;
        if (bus.req1_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_next_grant got=%b want=1", bus.req1_ready);
        end
        @(posedge clk); @(negedge clk);
        rst_n = 0;
        bus.req1_valid = 0;
        @(posedge clk); @(negedge clk);
        rst_n = 1;
        repeat (3) begin
            @(posedge clk); @(negedge clk);
            n_chk++;
            if ({bus.req0_ready, bus.req1_ready,
                 bus.rsp0_valid, bus.rsp1_valid} !== 4'b0) begin
                n_fail++;
                $display("FAIL bp_abort got=%b%b%b%b want=0000",
                         bus.req0_ready, bus.req1_ready,
                         bus.rsp0_valid, bus.rsp1_valid);
            end
        end
        prio_m = 1'b0;
        drive(1'b0, 11'd0, 11'd0, 1'b0);
        drive(1'b1, 11'd0, 11'd0, 1'b0);
        #1;
        n_chk++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_prio_reset got=%b%b want=10",
                     bus.req0_ready, bus.req1_ready);
        end
        clear_inputs();
        @(negedge clk);
    endtask

`ifdef ADDER_SUB_EN
    task automatic test_sub();
        logic [W:0] exp;
        exp = ref_op(11'd5, 11'd7, 1'b0, 1'b1);
        drive(1'b0, 11'd5, 11'd7, 1'b0);
        bus.req0_sub = 1;
        @(posedge clk); @(negedge clk);
        clear_inputs();
        @(posedge clk); @(negedge clk);
        n_chk++;
        if (bus.rsp0_valid !== 1'b1 || bus.rsp_sum !== 11'h7FE
            || bus.rsp_cout !== 1'b0
            || {bus.rsp_cout, bus.rsp_sum} !== exp) begin
            n_fail++;
            $display("FAIL sub_5_7 v=%b c=%b s=%h want c=0 s=7fe",
                     bus.rsp0_valid, bus.rsp_cout, bus.rsp_sum);
        end
        bus.rsp0_ready = 1;
        @(posedge clk); @(negedge clk);
        clear_inputs();
    endtask
`endif

    initial begin
        clear_inputs();
        test_reset();
        test_single(1'b0, 11'd100, 11'd23, 1'b1);
        test_single(1'b1, 11'h7FF, 11'h001, 1'b0);
        test_contention();
        test_backpressure();
`ifdef ADDER_SUB_EN
        test_sub();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end
endmodule
